// File: rtl/eq_tap_bank.sv
// eq_tap_bank: builds one band's ramp coefficients (tap k = k * gain) a tap per cycle into
// a shadow bank, then commits them atomically. Define TAP_SAT_EN to clamp taps at the rails.
module eq_tap_bank #(
    parameter int  NBANDS = 4,
    parameter int  NTAPS  = 8,
    parameter int  TAP_W  = 16,
    parameter int  GAIN_W = 8,
    localparam int BAND_W = (NBANDS > 1) ? $clog2(NBANDS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          eq_valid,
    output logic                          eq_ready,
    input  logic [BAND_W-1:0]             eq_band,
    input  logic [GAIN_W-1:0]             eq_gain,
    output logic [NBANDS*NTAPS*TAP_W-1:0] allTaps,
    output logic [NBANDS-1:0]             taps_upd
);

    localparam int             K_W    = $clog2(NTAPS);
    localparam logic [K_W-1:0] K_LAST = K_W'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUILD,
        COMMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [BAND_W-1:0]       band_q;
    logic [GAIN_W-1:0]       gain_q;
    logic [K_W-1:0]          k;
    logic signed [TAP_W:0]   acc;
    logic signed [TAP_W:0]   acc_next;
    logic signed [TAP_W:0]   gain_ext;
    logic signed [TAP_W:0]   sum;
    logic [TAP_W-1:0]        shadow [NTAPS];
    logic                    handshake;

    assign eq_ready  = (state == IDLE);
    assign handshake = eq_valid && eq_ready;

    // acc carries one guard bit, so a TAP_W-range value plus a sign-extended gain never overflows it.
    assign gain_ext = {{(TAP_W + 1 - GAIN_W){gain_q[GAIN_W-1]}}, gain_q};
    assign sum      = acc + gain_ext;

`ifdef TAP_SAT_EN
    localparam logic signed [TAP_W:0] MAX_TAP = {2'b00, {(TAP_W - 1){1'b1}}};
    localparam logic signed [TAP_W:0] MIN_TAP = {2'b11, {(TAP_W - 1){1'b0}}};

    always_comb begin
        if (sum > MAX_TAP) begin
            acc_next = MAX_TAP;
        end else if (sum < MIN_TAP) begin
            acc_next = MIN_TAP;
        end else begin
            acc_next = sum;
        end
    end
`else
    // Only the low TAP_W bits reach the taps, giving modulo 2^TAP_W wrap.
    assign acc_next = sum;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: next-state defaults to the current state before the case so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = BUILD;
            BUILD:   if (k == K_LAST) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shadow bank is reset explicitly so an aborted build can never leak stale taps.
            band_q   <= '0;
            gain_q   <= '0;
            k        <= '0;
            acc      <= '0;
            allTaps  <= '0;
            taps_upd <= '0;
            for (int t = 0; t < NTAPS; t++) begin
                shadow[t] <= '0;
            end
        end else begin
            // NOTE: all register updates use non-blocking assignment so every read sees pre-edge values.
            taps_upd <= '0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        band_q <= eq_band;
                        gain_q <= eq_gain;
                        k      <= '0;
                        acc    <= '0;
                    end
                end
                BUILD: begin
                    shadow[k] <= acc[TAP_W-1:0];
                    acc       <= acc_next;
                    k         <= k + K_W'(1);
                end
                COMMIT: begin
                    // An out-of-range band matches no slice, so nothing is written or pulsed.
                    for (int b = 0; b < NBANDS; b++) begin
                        if (int'(band_q) == b) begin
                            for (int t = 0; t < NTAPS; t++) begin
                                allTaps[(b*NTAPS + NTAPS - 1 - t)*TAP_W +: TAP_W] <= shadow[t];
                            end
                            taps_upd[b] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/eq_tap_bank.md
# eq_tap_bank

Sequential coefficient builder for the multi-band equalizer filter bank. It accepts one band/gain request at a time over a valid/ready handshake and generates that band's NTAPS ramp coefficients (tap k = k × gain) one tap per cycle into a shadow register. It then commits all taps atomically to the active tap bus that feeds the recursive filters. It supersedes the single-band, fixed 8×16-bit tap generator by adding a band count, tap count and width, a handshake, double buffering, and optional saturation.

## Interface
- NBANDS, 4: number of independent bands (tap sets).
- NTAPS, 8: taps per band, ≥2.
- TAP_W, 16: signed tap width.
- GAIN_W, 8: signed gain width, ≤ TAP_W.
- BAND_W, max(1,$clog2(NBANDS)): band index width (derived).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- eq_valid  in  1  request valid.
- eq_ready  out  1  block idle and able to accept a request.
- eq_band  in  BAND_W  target band.
- eq_gain  in  GAIN_W  signed two's-complement gain (eqVal).
- allTaps  out  NBANDS*NTAPS*TAP_W  active taps. Band b occupies slice [b*NTAPS*TAP_W +: NTAPS*TAP_W]. Within a band, tap k sits at [(NTAPS-1-k)*TAP_W +: TAP_W], so tap 0 is most significant.
- taps_upd  out  NBANDS  one-cycle pulse per band when that band's active taps change.

## Operation
- FSM states: IDLE, BUILD, COMMIT. eq_ready = (state==IDLE).
- IDLE: when eq_valid && eq_ready at an edge, latch band and gain, set k=0 and acc=0, and go to BUILD.
- BUILD: on each edge, write shadow[k]=acc, set acc=acc+sext(gain), and increment k. After shadow[NTAPS-1] is written, go to COMMIT.
- COMMIT: on one edge, copy shadow into the active slice of the latched band, pulse taps_upd[band] for one cycle, and go to IDLE.
- Band index ≥ NBANDS: the request is accepted and runs the full FSM. COMMIT writes nothing and no taps_upd pulse is issued.
- Arithmetic: acc is TAP_W+1 bits, signed. Saturation or wrap behaviour is set by the Configuration macro.
- Other bands' active taps never change during a build.
- Inputs are ignored outside the IDLE handshake.

## Timing
- Reset (asynchronous, while low): state=IDLE, eq_ready=1, allTaps=0, taps_upd=0, shadow=0, k=0, acc=0.
- Reset mid-build: the partial shadow is discarded and no commit occurs.
- Handshake at edge E0 → taps written at E1..E_NTAPS → commit at E_(NTAPS+1). allTaps and taps_upd are valid after E_(NTAPS+1).
- eq_ready is low from after E0 until after E_(NTAPS+1). Minimum request spacing is NTAPS+2 cycles.
- With eq_valid held high continuously, the next request is accepted at E_(NTAPS+2).
- All outputs are registered. There is no combinational path from inputs to outputs, except eq_ready, which is decoded from state.

## Configuration
- TAP_SAT_EN defined: each acc update clamps to [-2^(TAP_W-1), 2^(TAP_W-1)-1]. Once clamped, the value stays at the rail (next add starts from the clamped value).
- TAP_SAT_EN undefined: taps take the low TAP_W bits of k×gain, i.e. modulo 2^TAP_W wrap. No clamp logic is synthesised.

## Test plan
(NBANDS=4, NTAPS=8, TAP_W=16, GAIN_W=8 unless stated)
- Reset low, then released: allTaps=0, eq_ready=1, taps_upd=0.
- Band 0, gain 8'h01 handshake at E0:
  - eq_ready low for 9 cycles.
  - taps_upd=4'b0001 for exactly one cycle after E9.
  - Band 0 slice = 128'h0000_0001_0002_0003_0004_0005_0006_0007.
- Band 2, gain 8'hF4 (-12): band 2 slice = 0000,FFF4,FFE8,FFDC,FFD0,FFC4,FFB8,FFAC (tap0..7). Bands 0, 1, 3 are unchanged.
- TAP_W=8, gain 8'h7F:
  - With TAP_SAT_EN: taps 00,7F,7F,7F,7F,7F,7F,7F.
  - Without TAP_SAT_EN: taps 00,7F,FE,7D,FC,7B,FA,79.
- eq_valid held high with gains 1 then 2 on band 1:
  - Second request is accepted only at E10.
  - Final band 1 taps = 0,2,4,...,14.
  - taps_upd[1] pulses twice.
- Reset asserted at E4 of a build on band 3 with nonzero prior taps: all outputs zero immediately, no taps_upd pulse, eq_ready=1.
